hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. It owns the instruction-fetch handshake FSM and the fetched-instruction hold buffer. It resolves load-use hazards and branch-in-decode hazards, and it generates per-stage stall and flush signals plus forwarding selects for the decode comparators and the execute ALU operands. It sits beside the datapath; the decode stage consumes its instruction output and forwarding selects.

---
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Fetch handshake FSM, fetch hold buffer, hazard stall/flush and
//            forwarding-select generation for the 5-stage MIPS pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl (
    input  logic        clk,
    input  logic        resetn,
    output logic        i_req,
    input  logic        i_data_ok,
    input  logic [31:0] i_data,
    output logic [31:0] instrF,
    input  logic        d_req,
    input  logic        d_data_ok,
    input  logic        branchD,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic [4:0]  rsE,
    input  logic [4:0]  rtE,
    input  logic [4:0]  rdE,
    input  logic        regwriteE,
    input  logic        memtoregE,
    input  logic [4:0]  rdM,
    input  logic        regwriteM,
    input  logic        memtoregM,
    input  logic [4:0]  rdW,
    input  logic        regwriteW,
    output logic        stallF,
    output logic        stallD,
    output logic        stallE,
    output logic        stallM,
    output logic        flushD,
    output logic        flushE,
    output logic        flushW,
    output logic [1:0]  fwdAD,
    output logic [1:0]  fwdBD,
    output logic [1:0]  fwdAE,
    output logic [1:0]  fwdBE,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_HOLD = 2'd2
    } fstate_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    fstate_t     state_q, state_d;
    logic [31:0] ibuf_q, ibuf_d;
    logic [31:0] cnt_q;

    logic w_lu, w_br, w_hazd, w_dstall, w_istall, w_adv;

    // Register 0 is hard-wired zero, so a write to it never creates a dependence.
    function automatic logic hit(input logic we, input logic [4:0] rd, input logic [4:0] r);
        return we && (rd != 5'd0) && (rd == r);
    endfunction

    always_comb begin
        w_lu     = memtoregE && (hit(regwriteE, rdE, rsD) || hit(regwriteE, rdE, rtD));
        w_br     = branchD && (hit(regwriteE, rdE, rsD) || hit(regwriteE, rdE, rtD) ||
                   (memtoregM && (hit(regwriteM, rdM, rsD) || hit(regwriteM, rdM, rtD))));
        w_hazd   = w_lu || w_br;
        w_dstall = d_req && !d_data_ok;
        w_istall = (state_q == F_IDLE) || ((state_q == F_REQ) && !i_data_ok);
        w_adv    = !(w_dstall || w_hazd);
    end

    always_comb begin
        stallM = w_dstall;
        stallE = w_dstall;
        flushW = w_dstall;
        stallD = w_dstall || w_hazd;
        flushE = !w_dstall && w_hazd;
        stallF = w_dstall || w_hazd || w_istall;
        flushD = !(w_dstall || w_hazd) && w_istall;
    end

    // Decode compares cannot use a load result still in M; that case stalls instead.
    always_comb begin
        fwdAD = FWD_RF;
        fwdBD = FWD_RF;
        fwdAE = FWD_RF;
        fwdBE = FWD_RF;
        if (hit(regwriteM, rdM, rsD) && !memtoregM) fwdAD = FWD_M;
        else if (hit(regwriteW, rdW, rsD))          fwdAD = FWD_W;
        if (hit(regwriteM, rdM, rtD) && !memtoregM) fwdBD = FWD_M;
        else if (hit(regwriteW, rdW, rtD))          fwdBD = FWD_W;
        if (hit(regwriteM, rdM, rsE))               fwdAE = FWD_M;
        else if (hit(regwriteW, rdW, rsE))          fwdAE = FWD_W;
        if (hit(regwriteM, rdM, rtE))               fwdBE = FWD_M;
        else if (hit(regwriteW, rdW, rtE))          fwdBE = FWD_W;
    end

    always_comb begin
        state_d = state_q;
        ibuf_d  = ibuf_q;
        i_req   = 1'b0;
        case (state_q)
            F_IDLE: state_d = F_REQ;
            F_REQ: begin
                i_req = 1'b1;
                if (i_data_ok && !w_adv) begin
                    ibuf_d  = i_data;
                    state_d = F_HOLD;
                end
            end
            F_HOLD: if (w_adv) state_d = F_REQ;
            default: state_d = F_IDLE;
        endcase
    end

    assign instrF    = (state_q == F_HOLD) ? ibuf_q : i_data;
    assign stall_cnt = cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= F_IDLE;
            ibuf_q  <= 32'd0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            ibuf_q  <= ibuf_d;
            if (stallF) cnt_q <= cnt_q + 32'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed self-checking bench for hazard_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        i_req, i_data_ok;
    logic [31:0] i_data, instrF;
    logic        d_req, d_data_ok, branchD;
    logic [4:0]  rsD, rtD, rsE, rtE, rdE, rdM, rdW;
    logic        regwriteE, memtoregE, regwriteM, memtoregM, regwriteW;
    logic        stallF, stallD, stallE, stallM, flushD, flushE, flushW;
    logic [1:0]  fwdAD, fwdBD, fwdAE, fwdBE;
    logic [31:0] stall_cnt;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] exp_cnt;

    hazard_ctrl dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_data_ok(i_data_ok), .i_data(i_data), .instrF(instrF),
        .d_req(d_req), .d_data_ok(d_data_ok), .branchD(branchD),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE), .rdE(rdE),
        .regwriteE(regwriteE), .memtoregE(memtoregE),
        .rdM(rdM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .rdW(rdW), .regwriteW(regwriteW),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .fwdAD(fwdAD), .fwdBD(fwdBD), .fwdAE(fwdAE), .fwdBE(fwdBE),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs then change away from the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_data_ok = 0; i_data = 0; d_req = 0; d_data_ok = 0; branchD = 0;
        rsD = 0; rtD = 0; rsE = 0; rtE = 0; rdE = 0; rdM = 0; rdW = 0;
        regwriteE = 0; memtoregE = 0; regwriteM = 0; memtoregM = 0; regwriteW = 0;
    endtask

    initial begin
        resetn = 1'b0;
        clear_inputs();
        #2;
        chk("rst_ireq",   {31'd0, i_req},  32'd0);
        chk("rst_stallF", {31'd0, stallF}, 32'd1);
        chk("rst_flushD", {31'd0, flushD}, 32'd1);
        chk("rst_cnt",    stall_cnt,       32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        #2;
        chk("idle_ireq",  {31'd0, i_req},  32'd0);
        chk("idle_stallF",{31'd0, stallF}, 32'd1);
        cyc(); exp_cnt = 32'd1;
        chk("req_ireq",   {31'd0, i_req},  32'd1);
        chk("req_cnt",    stall_cnt,       exp_cnt);

        // A: load-use with a fetch returning in the same cycle
        memtoregE = 1; regwriteE = 1; rdE = 2; rsD = 2;
        i_data_ok = 1; i_data = 32'h24020005;
        #2;
        chk("lu_stallF", {31'd0, stallF}, 32'd1);
        chk("lu_stallD", {31'd0, stallD}, 32'd1);
        chk("lu_flushE", {31'd0, flushE}, 32'd1);
        chk("lu_stallE", {31'd0, stallE}, 32'd0);
        chk("lu_flushD", {31'd0, flushD}, 32'd0);
        cyc(); exp_cnt++;

        // B: load now in M, held word served from ibuf
        memtoregE = 0; regwriteE = 0; rdE = 0;
        rdM = 2; regwriteM = 1; memtoregM = 1;
        i_data_ok = 0; i_data = 32'h0;
        #2;
        chk("hold_ireq",   {31'd0, i_req},  32'd0);
        chk("hold_stallF", {31'd0, stallF}, 32'd1 & 32'd0);
        chk("hold_stallD", {31'd0, stallD}, 32'd0);
        chk("hold_instr",  instrF,          32'h24020005);
        cyc();

        // C: load in W forwards to E
        rdM = 0; regwriteM = 0; memtoregM = 0;
        rdW = 2; regwriteW = 1; rsE = 2; rtE = 2; rsD = 0;
        i_data_ok = 1;
        #2;
        chk("w_ireq",  {31'd0, i_req}, 32'd1);
        chk("w_fwdAE", {30'd0, fwdAE}, 32'd2);
        chk("w_fwdBE", {30'd0, fwdBE}, 32'd2);
        chk("w_stallF",{31'd0, stallF},32'd0);
        cyc();

        // D: branch in D depends on ALU op in E
        rdW = 0; regwriteW = 0; rsE = 0; rtE = 0;
        regwriteE = 1; rdE = 3; branchD = 1; rsD = 3; rtD = 0;
        i_data_ok = 1; i_data = 32'h1000FFFF;
        #2;
        chk("br_stallF", {31'd0, stallF}, 32'd1);
        chk("br_stallD", {31'd0, stallD}, 32'd1);
        chk("br_flushE", {31'd0, flushE}, 32'd1);
        cyc(); exp_cnt++;

        // E: ALU result in M feeds the branch compare
        regwriteE = 0; rdE = 0;
        rdM = 3; regwriteM = 1; memtoregM = 0;
        i_data_ok = 0; i_data = 32'h0;
        #2;
        chk("br_fwdAD",  {30'd0, fwdAD},  32'd1);
        chk("br_fwdBD",  {30'd0, fwdBD},  32'd0);
        chk("br2_stallD",{31'd0, stallD}, 32'd0);
        chk("br_instr",  instrF,          32'h1000FFFF);
        chk("br_cnt",    stall_cnt,       exp_cnt);
        cyc();

        // F: branch on a load still in M stalls and does not forward
        memtoregM = 1; i_data_ok = 1;
        #2;
        chk("brld_stallD", {31'd0, stallD}, 32'd1);
        chk("brld_fwdAD",  {30'd0, fwdAD},  32'd0);
        cyc(); exp_cnt++;

        // G: clean cycle in F_HOLD releases back to F_REQ
        clear_inputs();
        #2;
        chk("g_stallF", {31'd0, stallF}, 32'd0);
        cyc();

        // H: data wait coincides with fetch return and a load-use hazard
        d_req = 1; d_data_ok = 0; i_data_ok = 1; i_data = 32'hAABBCCDD;
        memtoregE = 1; regwriteE = 1; rdE = 7; rsD = 7;
        #2;
        chk("dw_flushE", {31'd0, flushE}, 32'd0);
        chk("dw_stallD", {31'd0, stallD}, 32'd1);
        chk("dw_stallM", {31'd0, stallM}, 32'd1);
        chk("dw_flushW", {31'd0, flushW}, 32'd1);
        cyc(); exp_cnt++;

        memtoregE = 0; regwriteE = 0; rdE = 0; rsD = 0;
        i_data_ok = 0; i_data = 32'h0;
        #2;
        chk("dw2_ireq",   {31'd0, i_req},  32'd0);
        chk("dw2_stallF", {31'd0, stallF}, 32'd1);
        cyc(); exp_cnt++;
        #2;
        chk("dw3_stallE", {31'd0, stallE}, 32'd1);
        chk("dw3_flushE", {31'd0, flushE}, 32'd0);
        cyc(); exp_cnt++;

        d_data_ok = 1;
        #2;
        chk("dw_done_stallF", {31'd0, stallF}, 32'd0);
        chk("dw_done_stallM", {31'd0, stallM}, 32'd0);
        chk("dw_done_instr",  instrF,          32'hAABBCCDD);
        chk("dw_cnt",         stall_cnt,       exp_cnt);
        cyc();

        // L: register 0 never forwards or stalls
        d_req = 0; d_data_ok = 0; i_data_ok = 1; i_data = 32'h11111111;
        rdM = 0; regwriteM = 1; rdW = 0; regwriteW = 1; rsE = 0;
        memtoregE = 1; regwriteE = 1; rdE = 0; rsD = 0; rtD = 0;
        #2;
        chk("r0_fwdAE",  {30'd0, fwdAE},  32'd0);
        chk("r0_stallD", {31'd0, stallD}, 32'd0);
        chk("r0_flushE", {31'd0, flushE}, 32'd0);
        chk("r0_instr",  instrF,          32'h11111111);
        cyc();

        // M: M beats W
        memtoregE = 0; regwriteE = 0;
        rdM = 5; regwriteM = 1; memtoregM = 0; rdW = 5; regwriteW = 1;
        rsE = 5; rtE = 5; rtD = 5; rsD = 0;
        #2;
        chk("pri_fwdAE", {30'd0, fwdAE}, 32'd1);
        chk("pri_fwdBE", {30'd0, fwdBE}, 32'd1);
        chk("pri_fwdBD", {30'd0, fwdBD}, 32'd1);
        chk("pri_fwdAD", {30'd0, fwdAD}, 32'd0);
        cyc();

        // N/O: enter F_HOLD, then reset asynchronously mid-cycle
        clear_inputs();
        memtoregE = 1; regwriteE = 1; rdE = 4; rsD = 4;
        i_data_ok = 1; i_data = 32'hCAFEF00D;
        cyc(); exp_cnt++;
        i_data_ok = 0; i_data = 32'h12345678;
        #2;
        chk("rh_ireq",  {31'd0, i_req}, 32'd0);
        chk("rh_instr", instrF,         32'hCAFEF00D);
        chk("rh_cnt",   stall_cnt,      exp_cnt);
        clear_inputs(); i_data = 32'h12345678;
        #1 resetn = 1'b0;
        #1;
        chk("ar_ireq",   {31'd0, i_req},  32'd0);
        chk("ar_cnt",    stall_cnt,       32'd0);
        chk("ar_stallF", {31'd0, stallF}, 32'd1);
        chk("ar_flushD", {31'd0, flushD}, 32'd1);
        chk("ar_instr",  instrF,          32'h12345678);
        cyc();
        resetn = 1'b1;
        repeat (2) cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
